// File: rtl/sfifo_rr_sched.sv
// Round-robin drain scheduler: grants one show-ahead FIFO at a time for up to
// BURST words and forwards its head word to a shared valid/ready sink.
module sfifo_rr_sched #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    parameter int SW    = $clog2(N),
    parameter int CW    = $clog2(BURST + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N-1:0]    f_empty,
    input  logic [N*DW-1:0] f_rd,
    output logic [N-1:0]    f_re,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [DW-1:0]   o_data,
    output logic [SW-1:0]   o_src,
    output logic            o_last,
    output logic [N-1:0]    gnt,
    output logic            busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t        state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] sel;
    logic [CW-1:0] cnt;

    logic [SW-1:0] winner;
    logic          found;
    logic [SW-1:0] sel_inc;
    logic          beat;
    logic          at_limit;
    int            idx;

    // First non-empty FIFO at or after ptr, wrapping modulo N.
    // NOTE: always_comb uses blocking assignments and gives every output a
    // default first, so no latch is inferred when no requester is found.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && !f_empty[idx]) begin
                found  = 1'b1;
                winner = SW'(idx);
            end
        end
    end

    // Explicit wrap keeps the rotation correct when N is not a power of two.
    assign sel_inc  = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;
    assign at_limit = (cnt == CW'(BURST - 1));

    // Reset gates the handshake so no word is popped on the reset cycle.
    assign o_valid = (state == XFER) && !f_empty[sel] && !reset;
    assign beat    = o_valid && o_ready;
    assign f_re    = beat ? (N'(1) << sel) : '0;
    assign o_last  = o_valid && at_limit;
    assign o_data  = f_rd[sel*DW +: DW];
    assign o_src   = sel;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en && found) begin
                        sel   <= winner;
                        cnt   <= '0;
                        gnt   <= N'(1) << winner;
                        busy  <= 1'b1;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        cnt <= cnt + 1'b1;
                        if (at_limit) begin
                            state <= IDLE;
                            ptr   <= sel_inc;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (f_empty[sel]) begin
                        state <= IDLE;
                        ptr   <= sel_inc;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfifo_rr_sched.sv
// Directed bench for sfifo_rr_sched: behavioural show-ahead FIFOs feed the
// scheduler; per-cycle vector tables plus hand-written corner sequences.
module tb_sfifo_rr_sched;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int SW    = 2;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [N-1:0]    f_empty;
    logic [N*DW-1:0] f_rd;
    logic [N-1:0]    f_re;
    logic            o_valid;
    logic            o_ready;
    logic [DW-1:0]   o_data;
    logic [SW-1:0]   o_src;
    logic            o_last;
    logic [N-1:0]    gnt;
    logic            busy;

    sfifo_rr_sched #(.N(N), .DW(DW), .BURST(BURST)) dut (
        .clk(clk), .reset(reset), .en(en), .f_empty(f_empty), .f_rd(f_rd),
        .f_re(f_re), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_src(o_src), .o_last(o_last), .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [N][DEPTH];
    int            rd  [N];
    int            wr  [N];

    typedef struct {
        logic          rst, en, rdy;
        logic          valid;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic          last;
        logic [N-1:0]  gnt, fre;
        logic          busy;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic rst, logic e, logic rdy, logic v, logic [SW-1:0] s,
                                logic [DW-1:0] d, logic l, logic [N-1:0] g,
                                logic [N-1:0] fr, logic b);
        vec_t r;
        r.rst = rst; r.en = e; r.rdy = rdy; r.valid = v; r.src = s; r.data = d;
        r.last = l; r.gnt = g; r.fre = fr; r.busy = b;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            f_empty[i]         = (rd[i] == wr[i]);
            f_rd[i*DW +: DW]   = mem[i][rd[i] % DEPTH];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
            for (int j = 0; j < DEPTH; j++) mem[i][j] = '0;
        end
        refresh();
    endtask

    task automatic push(input int s, input logic [DW-1:0] d);
        mem[s][wr[s] % DEPTH] = d;
        wr[s]++;
        refresh();
    endtask

    task automatic drive(input logic r, input logic e, input logic rdy);
        reset   = r;
        en      = e;
        o_ready = rdy;
        refresh();
        @(negedge clk);
    endtask

    task automatic tick();
        logic [N-1:0] fre_s;
        fre_s = f_re;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fre_s[i]) rd[i]++;
        refresh();
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].rdy);
            check($sformatf("row%0d_valid", i), 32'(o_valid), 32'(tbl[i].valid));
            check($sformatf("row%0d_src", i),   32'(o_src),   32'(tbl[i].src));
            check($sformatf("row%0d_last", i),  32'(o_last),  32'(tbl[i].last));
            check($sformatf("row%0d_gnt", i),   32'(gnt),     32'(tbl[i].gnt));
            check($sformatf("row%0d_fre", i),   32'(f_re),    32'(tbl[i].fre));
            check($sformatf("row%0d_busy", i),  32'(busy),    32'(tbl[i].busy));
            if (tbl[i].valid)
                check($sformatf("row%0d_data", i), 32'(o_data), 32'(tbl[i].data));
            tick();
        end
    endtask

    initial begin
        int beats;
        int ecnt;

        reset = 1'b1; en = 1'b0; o_ready = 1'b0;
        clear_model();

        // Single source: FIFO 2 holds three words.
        tbl[0]  = mk(1,1,1, 0,2'd0,8'h00,0,4'b0000,4'b0000,0);
        tbl[1]  = mk(0,1,1, 0,2'd0,8'h00,0,4'b0000,4'b0000,0);
        tbl[2]  = mk(0,1,1, 1,2'd2,8'hA1,0,4'b0100,4'b0100,1);
        tbl[3]  = mk(0,1,1, 1,2'd2,8'hA2,0,4'b0100,4'b0100,1);
        tbl[4]  = mk(0,1,1, 1,2'd2,8'hA3,0,4'b0100,4'b0100,1);
        tbl[5]  = mk(0,1,1, 0,2'd2,8'h00,0,4'b0100,4'b0000,1);
        tbl[6]  = mk(0,1,1, 0,2'd2,8'h00,0,4'b0000,4'b0000,0);
        // Burst limit: FIFO 0 holds six words.
        tbl[7]  = mk(0,1,1, 0,2'd2,8'h00,0,4'b0000,4'b0000,0);
        tbl[8]  = mk(0,1,1, 1,2'd0,8'hB0,0,4'b0001,4'b0001,1);
        tbl[9]  = mk(0,1,1, 1,2'd0,8'hB1,0,4'b0001,4'b0001,1);
        tbl[10] = mk(0,1,1, 1,2'd0,8'hB2,0,4'b0001,4'b0001,1);
        tbl[11] = mk(0,1,1, 1,2'd0,8'hB3,1,4'b0001,4'b0001,1);
        tbl[12] = mk(0,1,1, 0,2'd0,8'h00,0,4'b0000,4'b0000,0);
        tbl[13] = mk(0,1,1, 1,2'd0,8'hB4,0,4'b0001,4'b0001,1);
        tbl[14] = mk(0,1,1, 1,2'd0,8'hB5,0,4'b0001,4'b0001,1);
        tbl[15] = mk(0,1,1, 0,2'd0,8'h00,0,4'b0001,4'b0000,1);
        tbl[16] = mk(0,1,1, 0,2'd0,8'h00,0,4'b0000,4'b0000,0);
        // Backpressure: ready pattern 1,0,0,1 inside FIFO 1's burst.
        tbl[17] = mk(0,1,1, 0,2'd0,8'h00,0,4'b0000,4'b0000,0);
        tbl[18] = mk(0,1,1, 1,2'd1,8'hC0,0,4'b0010,4'b0010,1);
        tbl[19] = mk(0,1,0, 1,2'd1,8'hC1,0,4'b0010,4'b0000,1);
        tbl[20] = mk(0,1,0, 1,2'd1,8'hC1,0,4'b0010,4'b0000,1);
        tbl[21] = mk(0,1,1, 1,2'd1,8'hC1,0,4'b0010,4'b0010,1);
        tbl[22] = mk(0,1,1, 1,2'd1,8'hC2,0,4'b0010,4'b0010,1);
        tbl[23] = mk(0,1,1, 1,2'd1,8'hC3,1,4'b0010,4'b0010,1);
        tbl[24] = mk(0,1,1, 0,2'd1,8'h00,0,4'b0000,4'b0000,0);

        drive(1'b1, 1'b0, 1'b0);
        tick();
        check("rst_data", 32'(o_data), 32'h00);

        push(2, 8'hA1); push(2, 8'hA2); push(2, 8'hA3);
        run_rows(0, 6);
        check("ptr_after_single", 32'(dut.ptr), 32'd3);

        for (int k = 0; k < 6; k++) push(0, 8'hB0 + 8'(k));
        run_rows(7, 16);
        check("ptr_after_limit", 32'(dut.ptr), 32'd1);

        for (int k = 0; k < 4; k++) push(1, 8'hC0 + 8'(k));
        run_rows(17, 24);
        check("ptr_after_bp", 32'(dut.ptr), 32'd2);

        // en gating: en drops after the grant, burst still runs to o_last.
        for (int k = 0; k < 6; k++) push(2, 8'hD0 + 8'(k));
        push(3, 8'hE0); push(3, 8'hE1);
        drive(1'b0, 1'b1, 1'b1);
        check("en_arb_busy", 32'(busy), 32'd0);
        tick();
        for (int b = 0; b < BURST; b++) begin
            drive(1'b0, 1'b0, 1'b1);
            check($sformatf("en_beat%0d_valid", b), 32'(o_valid), 32'd1);
            check($sformatf("en_beat%0d_data", b),  32'(o_data),  32'(8'hD0 + 8'(b)));
            check($sformatf("en_beat%0d_last", b),  32'(o_last),  32'(b == BURST - 1));
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 1'b1);
            check($sformatf("en_off%0d_gnt", c),  32'(gnt),  32'd0);
            check($sformatf("en_off%0d_busy", c), 32'(busy), 32'd0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1);
        check("en_rearb_gnt", 32'(gnt), 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1);
        check("en_regrant_gnt",  32'(gnt),    32'b1000);
        check("en_regrant_data", 32'(o_data), 32'hE0);
        tick();

        // Reset in the second beat of FIFO 1's burst.
        clear_model();
        drive(1'b1, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) push(1, 8'h50 + 8'(k));
        drive(1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1);
        check("rmb_beat1_data", 32'(o_data), 32'h50);
        tick();
        drive(1'b1, 1'b1, 1'b1);
        check("rmb_rstcyc_fre", 32'(f_re), 32'd0);
        tick();
        push(0, 8'h60);
        drive(1'b0, 1'b1, 1'b1);
        check("rmb_after_busy", 32'(busy),    32'd0);
        check("rmb_after_fre",  32'(f_re),    32'd0);
        check("rmb_after_ptr",  32'(dut.ptr), 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1);
        check("rmb_restart_gnt",  32'(gnt),    32'b0001);
        check("rmb_restart_data", 32'(o_data), 32'h60);
        tick();
        drive(1'b0, 1'b1, 1'b1);
        check("rmb_release_valid", 32'(o_valid), 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1);
        check("rmb_kept_src",  32'(o_src),  32'd1);
        check("rmb_kept_data", 32'(o_data), 32'h51);
        tick();

        // Fairness: all four FIFOs loaded; expect 0,1,2,3,0,1,2,3 with 4 beats each.
        clear_model();
        drive(1'b1, 1'b1, 1'b1);
        tick();
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 8; k++) push(s, DW'((s << 4) | k));
        beats = 0;
        for (int c = 0; c < 80 && beats < 32; c++) begin
            drive(1'b0, 1'b1, 1'b1);
            if (o_valid) begin
                ecnt = beats % BURST;
                check($sformatf("rr%0d_src", beats),  32'(o_src),  32'((beats / BURST) % N));
                check($sformatf("rr%0d_data", beats), 32'(o_data),
                      32'(((beats / BURST) % N) << 4 | ((beats / (BURST * N)) * BURST + ecnt)));
                check($sformatf("rr%0d_last", beats), 32'(o_last), 32'(ecnt == BURST - 1));
                beats++;
            end
            tick();
        end
        check("rr_beat_count", 32'(beats), 32'd32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
